// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch command sequencer: op codes, FSM states, requester ids.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_RESET   = 2'b01,
        OP_SET     = 2'b10,
        OP_ILLEGAL = 2'b11
    } sr_op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK,
        RESP
    } sr_state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin arbiter; the pointer passes to the other requester after each accept.
module sr_rr_arb2
    import sr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id,
    output logic       accept
);

    logic ptr_q;

    always_comb begin
        grant = '0;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (ptr_q == REQ_B) ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    assign grant_id = grant[1];
    assign accept   = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_A;
        end else if (accept) begin
            ptr_q <= ~grant_id;
        end
    end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// Sequences set/reset commands from two requesters onto an SR latch bank (setup, pulse, hold).
// Optional readback verification of q/q_bar is enabled with SR_READBACK_CHECK_EN.
module sr_cmd_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LATCH = 4,
    parameter int unsigned IDX_W     = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*IDX_W-1:0]   req_idx,
    input  logic [3:0]           req_op,
    output logic [NUM_LATCH-1:0] latch_s,
    output logic [NUM_LATCH-1:0] latch_r,
    output logic [NUM_LATCH-1:0] latch_en,
    input  logic [NUM_LATCH-1:0] q_in,
    input  logic [NUM_LATCH-1:0] q_bar_in,
    output logic                 done,
    output logic                 done_id,
    output logic                 err_illegal,
    output logic                 err_check
);

    sr_state_e state_q, state_d;
    logic [IDX_W-1:0]     idx_q, c_idx;
    sr_op_e               op_q, c_op;
    logic                 id_q, gid, accept, c_bad, rb_ok;
    logic [NUM_LATCH-1:0] c_sel, q_sel, s_d, r_d, en_d;
    logic                 done_d, done_id_d, err_ill_d, err_chk_d;

    sr_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (req_valid),
        .enable   (state_q == IDLE),
        .grant    (req_ready),
        .grant_id (gid),
        .accept   (accept)
    );

    assign c_idx = gid ? req_idx[2*IDX_W-1:IDX_W] : req_idx[IDX_W-1:0];
    assign c_op  = sr_op_e'(gid ? req_op[3:2] : req_op[1:0]);
    assign c_bad = (c_op == OP_ILLEGAL) || (32'(c_idx) >= NUM_LATCH);

    // One-hot decode avoids selecting with an index wider than the cell range.
    always_comb begin
        c_sel = '0;
        q_sel = '0;
        for (int unsigned i = 0; i < NUM_LATCH; i++) begin
            if (c_idx == IDX_W'(i)) c_sel[i] = 1'b1;
            if (idx_q == IDX_W'(i)) q_sel[i] = 1'b1;
        end
    end

`ifdef SR_READBACK_CHECK_EN
    assign rb_ok = ((|(q_in & q_sel)) == op_q[1]) && ((|(q_bar_in & q_sel)) == ~op_q[1]);
`else
    logic unused_rb;
    assign unused_rb = ^{q_in, q_bar_in};
    assign rb_ok     = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        s_d       = '0;
        r_d       = '0;
        en_d      = '0;
        done_d    = 1'b0;
        done_id_d = 1'b0;
        err_ill_d = 1'b0;
        err_chk_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (c_bad) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        done_id_d = gid;
                        err_ill_d = 1'b1;
                    end else if (c_op == OP_NOP) begin
                        state_d   = RESP;
                        done_d    = 1'b1;
                        done_id_d = gid;
                    end else begin
                        state_d = SETUP;
                        s_d     = c_sel & {NUM_LATCH{c_op[1]}};
                        r_d     = c_sel & {NUM_LATCH{c_op[0]}};
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                s_d     = latch_s;
                r_d     = latch_r;
                en_d    = q_sel;
            end
            PULSE: begin
                state_d = HOLD;
                s_d     = latch_s;
                r_d     = latch_r;
            end
            HOLD: begin
                state_d   = CHECK;
                done_d    = 1'b1;
                done_id_d = id_q;
                // An unknown readback leaves rb_ok non-1 and falls to the mismatch branch.
                if (rb_ok) err_chk_d = 1'b0;
                else       err_chk_d = 1'b1;
            end
            CHECK:   state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_q        <= OP_NOP;
            id_q        <= REQ_A;
            latch_s     <= '0;
            latch_r     <= '0;
            latch_en    <= '0;
            done        <= 1'b0;
            done_id     <= 1'b0;
            err_illegal <= 1'b0;
            err_check   <= 1'b0;
        end else begin
            state_q     <= state_d;
            latch_s     <= s_d;
            latch_r     <= r_d;
            latch_en    <= en_d;
            done        <= done_d;
            done_id     <= done_id_d;
            err_illegal <= err_ill_d;
            err_check   <= err_chk_d;
            if (accept) begin
                idx_q <= c_idx;
                op_q  <= c_op;
                id_q  <= gid;
            end
        end
    end

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed bench for sr_cmd_arbiter with a small SR latch model driving q_in/q_bar_in.
module tb_sr_cmd_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_idx;
    logic [3:0] req_op;
    logic [3:0] latch_s, latch_r, latch_en, q_in, q_bar_in;
    logic       done, done_id, err_illegal, err_check;

    logic [3:0] mq;
    logic       force_low1;
    int         checks;
    int         failures;
    logic       exp_rb_err;

    sr_cmd_arbiter #(.NUM_LATCH(4), .IDX_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_idx     (req_idx),
        .req_op      (req_op),
        .latch_s     (latch_s),
        .latch_r     (latch_r),
        .latch_en    (latch_en),
        .q_in        (q_in),
        .q_bar_in    (q_bar_in),
        .done        (done),
        .done_id     (done_id),
        .err_illegal (err_illegal),
        .err_check   (err_check)
    );

    always #5 clk = ~clk;

    initial mq = 4'b0000;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (latch_en[i] === 1'b1) mq[i] <= latch_s[i] ? 1'b1 : (latch_r[i] ? 1'b0 : mq[i]);
        end
    end
    assign q_in     = force_low1 ? (mq & 4'b1101) : mq;
    assign q_bar_in = ~q_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            assert (((latch_s & latch_r) === 4'b0000) && ($countones(latch_en) <= 1)) else begin
                failures++;
                $error("FAIL invariant observed=s%0h/r%0h/en%0h expected=disjoint,onehot0",
                       latch_s, latch_r, latch_en);
            end
        end
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; force_low1 = 1'b0;
        req_valid = 2'b00; req_idx = '0; req_op = '0;
`ifdef SR_READBACK_CHECK_EN
        exp_rb_err = 1'b1;
`else
        exp_rb_err = 1'b0;
`endif
        checks = 0; failures = 0;
        repeat (2) @(negedge clk);
        chk("rst_s", latch_s, 4'h0);
        chk("rst_en", latch_en, 4'h0);
        chk("rst_done", {done, done_id, err_illegal, err_check}, 4'h0);
        chk("rst_ready", req_ready, 2'b00);
        rst_n = 1'b1;

        // A: set idx 2
        req_idx = {3'd0, 3'd2}; req_op = {2'b00, 2'b10}; req_valid = 2'b01;
        chk("t1_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk("t1_s1", {latch_s, latch_r, latch_en}, {4'b0100, 4'b0000, 4'b0000});
        step();
        chk("t1_s2", {latch_s, latch_en}, {4'b0100, 4'b0100});
        step();
        chk("t1_s3", {latch_s, latch_en, done}, {4'b0100, 4'b0000, 1'b0});
        step();
        chk("t1_done", {latch_s, done, done_id, err_check}, {4'b0000, 1'b1, 1'b0, 1'b0});
        chk("t1_model", mq[2], 1'b1);
        step();
        chk("t1_after", done, 1'b0);

        // Both valid after reset: A reset idx0 wins, B set idx1 waits
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        req_idx = {3'd1, 3'd0}; req_op = {2'b10, 2'b01}; req_valid = 2'b11;
        chk("t2_ready_a", req_ready, 2'b01);
        step(); req_valid = 2'b10;
        chk("t2_r", {latch_s, latch_r}, {4'b0000, 4'b0001});
        chk("t2_busy", req_ready, 2'b00);
        step(); step(); step();
        chk("t2_done_a", {done, done_id, req_ready}, {1'b1, 1'b0, 2'b00});
        step();
        chk("t2_ready_b", {req_ready, done}, {2'b10, 1'b0});
        step(); req_valid = 2'b00;
        chk("t2_s_b", latch_s, 4'b0010);
        step(); step(); step();
        chk("t2_done_b", {done, done_id}, {1'b1, 1'b1});
        chk("t2_model", mq[1:0], 2'b10);
        step();
        req_idx = {3'd1, 3'd0}; req_op = {2'b01, 2'b00}; req_valid = 2'b11;
        chk("t2_ptr_a", req_ready, 2'b01);
        step(); req_valid = 2'b10;
        chk("t2_nop", {done, done_id, err_illegal, latch_s, latch_r, latch_en},
            {1'b1, 1'b0, 1'b0, 12'h000});
        chk("t2_resp_busy", req_ready, 2'b00);
        step();
        chk("t2_ready_b2", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        chk("t2_r_b", latch_r, 4'b0010);
        step(); step(); step();
        chk("t2_done_b2", {done, done_id}, {1'b1, 1'b1});
        step();

        // A illegal op
        req_idx = {3'd0, 3'd0}; req_op = {2'b00, 2'b11}; req_valid = 2'b01;
        chk("t3_ready", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk("t3_err", {err_illegal, done, done_id, latch_s, latch_r, latch_en},
            {1'b1, 1'b1, 1'b0, 12'h000});
        step();
        chk("t3_clear", {err_illegal, done}, 2'b00);

        // B set out-of-range idx 7
        req_idx = {3'd7, 3'd0}; req_op = {2'b10, 2'b00}; req_valid = 2'b10;
        chk("t4_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00;
        chk("t4_err", {err_illegal, done, done_id, latch_s, latch_r}, {1'b1, 1'b1, 1'b1, 8'h00});
        step();
        chk("t4_quiet", {err_illegal, done, latch_en, latch_s}, 10'h000);

        // Reset during PULSE
        req_idx = {3'd0, 3'd3}; req_op = {2'b00, 2'b10}; req_valid = 2'b01;
        step(); req_valid = 2'b00;
        step();
        chk("t5_pulse", latch_en, 4'b1000);
        rst_n = 1'b0; #1;
        chk("t5_async", {latch_en, latch_s, done}, 9'h000);
        req_idx = {3'd1, 3'd0}; req_op = {2'b10, 2'b10}; req_valid = 2'b11;
        @(negedge clk);
        chk("t5_in_rst", done, 1'b0);
        rst_n = 1'b1; #1;
        chk("t5_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        step();
        chk("t5_no_done1", done, 1'b0);
        step();
        chk("t5_no_done2", {done, latch_s, latch_en}, 9'h000);

        // Readback mismatch: A set idx1 with q_in[1] held low
        force_low1 = 1'b1;
        req_idx = {3'd0, 3'd1}; req_op = {2'b00, 2'b10}; req_valid = 2'b01;
        step(); req_valid = 2'b00;
        step(); step(); step();
        chk("t6_done", {done, done_id}, {1'b1, 1'b0});
        chk("t6_err_check", err_check, exp_rb_err);
        step();
        force_low1 = 1'b0;
        chk("t6_clear", {done, err_check}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
